// File: rtl/alu_log_unit_if.sv
// Chip-select/ready handshake between the ALU controller and the logic/rotate unit.
interface alu_log_unit_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             cs;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] out;
    logic             zf;
    logic             rdy;

    // Controller side: issues requests, consumes results
    modport master (
        output cs, op, A, B,
        input  out, zf, rdy
    );

    // Unit side: accepts requests, returns results
    modport slave (
        input  cs, op, A, B,
        output out, zf, rdy
    );
endinterface

// File: rtl/alu_log_unit.sv
// Multi-cycle logic/rotate unit (ALU op codes 4-7). AND/OR/XOR finish in one RUN cycle;
// ROL rotates one bit per cycle, so latency grows with the rotate count.
module alu_log_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_log_unit_if.slave   bus
);

    localparam logic [1:0] OpAnd = 2'b00;
    localparam logic [1:0] OpOr  = 2'b01;
    localparam logic [1:0] OpXor = 2'b10;
    localparam logic [1:0] OpRol = 2'b11;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zf_q, zf_d;
    logic             rdy_q, rdy_d;
    logic [WIDTH-1:0] logic_res;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand, counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            acc_q <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            out_q <= '0;
            zf_q  <= 1'b0;
            rdy_q <= 1'b0;
        end else begin
            op_q  <= op_d;
            acc_q <= acc_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
            out_q <= out_d;
            zf_q  <= zf_d;
            rdy_q <= rdy_d;
        end
    end

    // Next-state: ROL stays in RUN until its count is exhausted
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.cs) state_d = StRun;
            StRun:  if (op_q != OpRol || cnt_q == '0) state_d = StDone;
            StDone: if (!bus.cs) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Logic-op result from latched operands
    always_comb begin
        logic_res = acc_q;
        unique case (op_q)
            OpAnd: logic_res = acc_q & b_q;
            OpOr:  logic_res = acc_q | b_q;
            OpXor: logic_res = acc_q ^ b_q;
            OpRol: logic_res = acc_q;
            default: logic_res = acc_q;
        endcase
    end

    // Datapath next values and registered outputs; rdy mirrors the DONE state
    always_comb begin
        op_d  = op_q;
        acc_d = acc_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        out_d = out_q;
        zf_d  = zf_q;
        unique case (state_q)
            StIdle: begin
                if (bus.cs) begin
                    op_d  = bus.op;
                    acc_d = bus.A;
                    b_d   = bus.B;
                    cnt_d = bus.B[SHW-1:0];
                end
            end
            StRun: begin
                if (op_q == OpRol) begin
                    if (cnt_q != '0) begin
                        acc_d = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]};
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        out_d = acc_q;
                        zf_d  = (acc_q == '0);
                    end
                end else begin
                    out_d = logic_res;
                    zf_d  = (logic_res == '0);
                end
            end
            StDone: ;
            default: ;
        endcase
        rdy_d = (state_d == StDone);
    end

    assign bus.out = out_q;
    assign bus.zf  = zf_q;
    assign bus.rdy = rdy_q;

endmodule
